// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the forwarding sources and the ID/EX stage.
// master drives ID fields, pipeline controls and forwarding taps; slave is the stage itself.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [3:0]      id_alu_ctrl;
    logic            id_src_a_pc;
    logic            id_src_b_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            exmem_reg_write;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic            ex_valid;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic            hazard_stall;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
               id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_ctrl, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_store_data, ex_pc, hazard_stall
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
               id_reg_write, id_mem_read, id_mem_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_ctrl, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_store_data, ex_pc, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding muxes and load-use hazard detection.
// Feeds the ALU operands/op code directly; operand selection is purely combinational.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [3:0]      alu_ctrl;
        logic            src_a_pc;
        logic            src_b_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_fields_t;

    ex_fields_t ex_reg;
    ex_fields_t ex_next;
    logic       hazard_stall;

    // Load in EX whose destination is read by a valid ID instruction.
    assign hazard_stall = ex_reg.valid & ex_reg.mem_read & (ex_reg.rd != '0) & bus.id_valid &
                          ((bus.id_rs1 == ex_reg.rd) | (bus.id_rs2 == ex_reg.rd));

    // Bubbles zero every field, so source indices become x0 and never forward.
    always_comb begin
        ex_next = ex_reg;
        if (bus.flush) begin
            ex_next = '0;
        end else if (bus.stall) begin
            ex_next = ex_reg;
        end else if (hazard_stall) begin
            ex_next = '0;
        end else begin
            ex_next.valid     = bus.id_valid;
            ex_next.pc        = bus.id_pc;
            ex_next.rs1_data  = bus.id_rs1_data;
            ex_next.rs2_data  = bus.id_rs2_data;
            ex_next.imm       = bus.id_imm;
            ex_next.rs1       = bus.id_rs1;
            ex_next.rs2       = bus.id_rs2;
            ex_next.rd        = bus.id_rd;
            ex_next.alu_ctrl  = bus.id_alu_ctrl;
            ex_next.src_a_pc  = bus.id_src_a_pc;
            ex_next.src_b_imm = bus.id_src_b_imm;
            ex_next.reg_write = bus.id_reg_write & bus.id_valid;
            ex_next.mem_read  = bus.id_mem_read  & bus.id_valid;
            ex_next.mem_write = bus.id_mem_write & bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg <= '0;
        end else begin
            ex_reg <= ex_next;
        end
    end

    logic [REGW-1:0] src_idx  [2];
    logic [XLEN-1:0] src_data [2];
    logic [XLEN-1:0] fwd_data [2];

    assign src_idx[0]  = ex_reg.rs1;
    assign src_idx[1]  = ex_reg.rs2;
    assign src_data[0] = ex_reg.rs1_data;
    assign src_data[1] = ex_reg.rs2_data;

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic exmem_hit;
            logic memwb_hit;
            assign exmem_hit = bus.exmem_reg_write & (bus.exmem_rd != '0) &
                               (bus.exmem_rd == src_idx[gi]);
            assign memwb_hit = bus.memwb_reg_write & (bus.memwb_rd != '0) &
                               (bus.memwb_rd == src_idx[gi]);
            assign fwd_data[gi] = exmem_hit ? bus.exmem_result :
                                  memwb_hit ? bus.memwb_result : src_data[gi];
        end
    endgenerate

    assign bus.alu_a         = ex_reg.src_a_pc  ? ex_reg.pc  : fwd_data[0];
    assign bus.alu_b         = ex_reg.src_b_imm ? ex_reg.imm : fwd_data[1];
    assign bus.ex_store_data = fwd_data[1];
    assign bus.alu_ctrl      = ex_reg.alu_ctrl;
    assign bus.ex_valid      = ex_reg.valid;
    assign bus.ex_rd         = ex_reg.rd;
    assign bus.ex_reg_write  = ex_reg.valid & ex_reg.reg_write;
    assign bus.ex_mem_read   = ex_reg.valid & ex_reg.mem_read;
    assign bus.ex_mem_write  = ex_reg.valid & ex_reg.mem_write;
    assign bus.ex_pc         = ex_reg.pc;
    assign bus.hazard_stall  = hazard_stall;
endmodule
